// File: rtl/contador_pkg.sv
`default_nettype none
// ============================================================================
// Module   : contador_pkg
// Purpose  : Shared types and constants for the counter display stage:
//            scan state enumeration, blank codes for segments and anodes,
//            and the active-low 7-segment code table (gfedcba).
// Revision : 1.0 - initial release
// ============================================================================
package contador_pkg;

  // Scan sequence: units digit, blank, tens digit, blank.
  typedef enum logic [1:0] {
    UNI  = 2'd0,
    BLK1 = 2'd1,
    DEZ  = 2'd2,
    BLK2 = 2'd3
  } estado_t;

  localparam logic [6:0] SEG_APAGADO = 7'h7F;
  localparam logic [1:0] AN_APAGADO  = 2'b11;
  localparam logic [1:0] AN_UNIDADE  = 2'b10;
  localparam logic [1:0] AN_DEZENA   = 2'b01;

  // Active-low segment codes for digits 0..9, bit order g,f,e,d,c,b,a.
  localparam logic [6:0] SEG_CODIGOS [0:9] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

  // Codes above 9 cannot come from the BCD stage; they map to blank so a
  // corrupted digit never lights a random pattern.
  function automatic logic [6:0] codigo_seg(input logic [3:0] digito);
    logic [6:0] r;
    r = SEG_APAGADO;
    if (digito <= 4'd9) begin
      r = SEG_CODIGOS[digito];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/contador_display_mux_decod.sv
`default_nettype none
// ============================================================================
// Module   : decod_7seg
// Purpose  : Combinational BCD digit to active-low 7-segment decoder.
// Ports    : digito [3:0] in  - BCD digit 0..9 (others decode to blank)
//            seg    [6:0] out - segments g,f,e,d,c,b,a, active-low
// Revision : 1.0 - initial release
// ============================================================================
module decod_7seg
  import contador_pkg::*;
(
  input  logic [3:0] digito,
  output logic [6:0] seg
);

  assign seg = codigo_seg(digito);

endmodule
`default_nettype wire

// File: rtl/contador_display_mux.sv
`default_nettype none
// ============================================================================
// Module   : contador_display_mux
// Purpose  : Consumer stage for a 4-bit up/down counter value. Registers the
//            value, flags each change and its direction, converts it to two
//            decimal digits and time-multiplexes two common-anode 7-segment
//            digits with a one-cycle blank slot between them.
// Params   : REFRESH_DIV - cycles each digit stays lit (>= 2)
// Macro    : CONTADOR_DISPLAY_BLANK_ZERO_EN - when defined, a tens digit of 0
//            is blanked (leading-zero suppression); anode still driven.
// Ports    : clock        in  - system clock, rising edge
//            resert       in  - asynchronous active-high reset
//            valor  [3:0] in  - counter value 0..15
//            seg    [6:0] out - segments g..a, active-low
//            an     [1:0] out - anodes, active-low; an[0]=units, an[1]=tens
//            direcao      out - 1 = last change upward, 0 = downward
//            mudou        out - one-cycle pulse per value change
// Revision : 1.0 - initial release
// ============================================================================
module contador_display_mux
  import contador_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clock,
  input  logic       resert,
  input  logic [3:0] valor,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       direcao,
  output logic       mudou
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  localparam logic [1:0] ST_UNI  = UNI;
  localparam logic [1:0] ST_BLK1 = BLK1;
  localparam logic [1:0] ST_DEZ  = DEZ;
  localparam logic [1:0] ST_BLK2 = BLK2;

  // --------------------------------------------------------------------------
  // Input stage and change detection
  // --------------------------------------------------------------------------
  logic [3:0] r_valor_q;
  logic [3:0] r_valor_ant;
  logic       r_direcao;
  logic       r_mudou;

  always_ff @(posedge clock or posedge resert) begin
    if (resert) begin
      r_valor_q   <= 4'd0;
      r_valor_ant <= 4'd0;
      r_direcao   <= 1'b1;
      r_mudou     <= 1'b0;
    end else begin
      r_valor_q   <= valor;
      r_valor_ant <= r_valor_q;
      r_mudou     <= (r_valor_q != r_valor_ant);
      // Plain unsigned compare: a 15->0 wrap from an upstream reset reads
      // as a downward step, which is the intended interpretation.
      if (r_valor_q != r_valor_ant) begin
        r_direcao <= (r_valor_q > r_valor_ant);
      end
    end
  end

  assign mudou   = r_mudou;
  assign direcao = r_direcao;

  // --------------------------------------------------------------------------
  // BCD split: value is at most 15, so the tens digit is a single bit.
  // --------------------------------------------------------------------------
  logic       r_dezena;
  logic [3:0] r_unidade;

  always_ff @(posedge clock or posedge resert) begin
    if (resert) begin
      r_dezena  <= 1'b0;
      r_unidade <= 4'd0;
    end else if (r_valor_q >= 4'd10) begin
      r_dezena  <= 1'b1;
      r_unidade <= r_valor_q - 4'd10;
    end else begin
      r_dezena  <= 1'b0;
      r_unidade <= r_valor_q;
    end
  end

  // --------------------------------------------------------------------------
  // Scan state machine
  // --------------------------------------------------------------------------
  logic [1:0]       r_estado;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       w_prox_estado;
  logic [CNT_W-1:0] w_prox_cnt;

  always_comb begin
    w_prox_estado = r_estado;
    w_prox_cnt    = r_cnt;
    case (r_estado)
      ST_UNI: begin
        if (r_cnt == C_CNT_MAX) begin
          w_prox_estado = ST_BLK1;
          w_prox_cnt    = '0;
        end else begin
          w_prox_cnt = r_cnt + 1'b1;
        end
      end
      ST_BLK1: begin
        w_prox_estado = ST_DEZ;
        w_prox_cnt    = '0;
      end
      ST_DEZ: begin
        if (r_cnt == C_CNT_MAX) begin
          w_prox_estado = ST_BLK2;
          w_prox_cnt    = '0;
        end else begin
          w_prox_cnt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_prox_estado = ST_UNI;
        w_prox_cnt    = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge resert) begin
    if (resert) begin
      r_estado <= ST_BLK2;
      r_cnt    <= '0;
    end else begin
      r_estado <= w_prox_estado;
      r_cnt    <= w_prox_cnt;
    end
  end

  // --------------------------------------------------------------------------
  // Output path: a single decoder is shared, its input chosen by the state
  // being entered so seg/an are registered Moore outputs of that state.
  // --------------------------------------------------------------------------
  logic [3:0] w_digito;
  logic [6:0] w_seg_dec;
  logic [6:0] w_seg_prox;
  logic [1:0] w_an_prox;

  assign w_digito = (w_prox_estado == ST_DEZ) ? {3'b000, r_dezena} : r_unidade;

  decod_7seg u_decod (
    .digito (w_digito),
    .seg    (w_seg_dec)
  );

  always_comb begin
    w_seg_prox = SEG_APAGADO;
    w_an_prox  = AN_APAGADO;
    case (w_prox_estado)
      ST_UNI: begin
        w_seg_prox = w_seg_dec;
        w_an_prox  = AN_UNIDADE;
      end
      ST_DEZ: begin
        w_an_prox = AN_DEZENA;
`ifdef CONTADOR_DISPLAY_BLANK_ZERO_EN
        w_seg_prox = r_dezena ? w_seg_dec : SEG_APAGADO;
`else
        w_seg_prox = w_seg_dec;
`endif
      end
      default: begin
        w_seg_prox = SEG_APAGADO;
        w_an_prox  = AN_APAGADO;
      end
    endcase
  end

  logic [6:0] r_seg;
  logic [1:0] r_an;

  always_ff @(posedge clock or posedge resert) begin
    if (resert) begin
      r_seg <= SEG_APAGADO;
      r_an  <= AN_APAGADO;
    end else begin
      r_seg <= w_seg_prox;
      r_an  <= w_an_prox;
    end
  end

  assign seg = r_seg;
  assign an  = r_an;

endmodule
`default_nettype wire

// File: tb/tb_contador_display_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_contador_display_mux
// Purpose  : Self-checking bench for contador_display_mux (REFRESH_DIV = 4).
//            A history of sampled input values drives a reference model
//            that derives every expected output from edge count and history.
// Revision : 1.0 - initial release
// ============================================================================
module tb_contador_display_mux;

  localparam int RDIV = 4;
  localparam int HMAX = 4095;

  logic       clock = 1'b0;
  logic       resert = 1'b0;
  logic [3:0] valor = 4'd0;
  logic [6:0] seg;
  logic [1:0] an;
  logic       direcao;
  logic       mudou;

  int checks = 0;
  int errors = 0;
  int k = 0;               // edges since reset release
  int hist [0:HMAX];       // hist[i] = valor sampled on edge i

  contador_display_mux #(.REFRESH_DIV(RDIV)) dut (
    .clock   (clock),
    .resert  (resert),
    .valor   (valor),
    .seg     (seg),
    .an      (an),
    .direcao (direcao),
    .mudou   (mudou)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  function automatic int h(input int i);
    if (i < 1 || i > HMAX) return 0;
    return hist[i];
  endfunction

  function automatic logic [6:0] dec(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  // Slot position within the 2*(RDIV+1) scan period for edge kk (kk >= 1).
  function automatic int pos(input int kk);
    return (kk - 1) % (2 * (RDIV + 1));
  endfunction

  function automatic logic [1:0] exp_an(input int kk);
    if (kk < 1) return 2'b11;
    if (pos(kk) < RDIV) return 2'b10;
    if (pos(kk) > RDIV && pos(kk) < 2 * RDIV + 1) return 2'b01;
    return 2'b11;
  endfunction

  // Value shown on edge kk was sampled two edges earlier.
  function automatic logic [6:0] exp_seg(input int kk);
    int v;
    if (kk < 1) return 7'h7F;
    v = h(kk - 2);
    if (pos(kk) < RDIV) return dec(v % 10);
    if (pos(kk) > RDIV && pos(kk) < 2 * RDIV + 1) begin
`ifdef CONTADOR_DISPLAY_BLANK_ZERO_EN
      if (v / 10 == 0) return 7'h7F;
`endif
      return dec(v / 10);
    end
    return 7'h7F;
  endfunction

  function automatic logic exp_mudou(input int kk);
    if (kk < 1) return 1'b0;
    return h(kk - 1) != h(kk - 2);
  endfunction

  function automatic logic exp_dir(input int kk);
    for (int j = kk - 1; j >= 1; j--) begin
      if (h(j) != h(j - 1)) return h(j) > h(j - 1);
    end
    return 1'b1;
  endfunction

  // Drive one value across one rising edge; leaves time at edge + 1.
  task automatic tick(input logic [3:0] v);
    valor = v;
    @(posedge clock);
    if (k < HMAX) k++;
    hist[k] = int'(v);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(posedge clock);
    #3;
    resert = 1'b1;
    #1;  // between edges: async reset must already show
    checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got %h exp 7f", seg); end
    checks++; if (an !== 2'b11) begin errors++; $display("FAIL reset_an got %b exp 11", an); end
    checks++; if (direcao !== 1'b1) begin errors++; $display("FAIL reset_dir got %b exp 1", direcao); end
    checks++; if (mudou !== 1'b0) begin errors++; $display("FAIL reset_mudou got %b exp 0", mudou); end
    valor = 4'd9;
    repeat (2) @(posedge clock);
    #3;
    checks++; if (seg !== 7'h7F || an !== 2'b11) begin errors++; $display("FAIL reset_hold seg %h an %b exp 7f 11", seg, an); end
    valor = 4'd0;
    resert = 1'b0;
    k = 0;
  endtask

  task automatic test_scan();
    for (int i = 0; i < 22; i++) begin
      tick(4'd0);
      checks++; if (an !== exp_an(k)) begin errors++; $display("FAIL scan_an k=%0d got %b exp %b", k, an, exp_an(k)); end
      checks++; if (seg !== exp_seg(k)) begin errors++; $display("FAIL scan_seg k=%0d got %b exp %b", k, seg, exp_seg(k)); end
    end
  endtask

  task automatic test_up();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      tick(4'd1);
      if (mudou === 1'b1) pulses++;
      checks++; if (mudou !== exp_mudou(k)) begin errors++; $display("FAIL up_mudou k=%0d got %b exp %b", k, mudou, exp_mudou(k)); end
      checks++; if (direcao !== exp_dir(k)) begin errors++; $display("FAIL up_dir k=%0d got %b exp %b", k, direcao, exp_dir(k)); end
      checks++; if (seg !== exp_seg(k) || an !== exp_an(k)) begin errors++; $display("FAIL up_disp k=%0d got %b/%b exp %b/%b", k, seg, an, exp_seg(k), exp_an(k)); end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL up_pulses got %0d exp 1", pulses); end
    checks++; if (direcao !== 1'b1) begin errors++; $display("FAIL up_final_dir got %b exp 1", direcao); end
  endtask

  task automatic test_two_digit();
    for (int i = 0; i < 14; i++) begin
      tick(4'd12);
      checks++; if (seg !== exp_seg(k) || an !== exp_an(k)) begin errors++; $display("FAIL two_digit k=%0d got %b/%b exp %b/%b", k, seg, an, exp_seg(k), exp_an(k)); end
    end
  endtask

  task automatic test_down_hold();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 3; i++) tick(4'd15);
    for (int i = 0; i < 8; i++) begin
      tick(4'd14);
      if (mudou === 1'b1) pulses++;
      checks++; if (mudou !== exp_mudou(k)) begin errors++; $display("FAIL down_mudou k=%0d got %b exp %b", k, mudou, exp_mudou(k)); end
      checks++; if (direcao !== exp_dir(k)) begin errors++; $display("FAIL down_dir k=%0d got %b exp %b", k, direcao, exp_dir(k)); end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL down_pulses got %0d exp 1", pulses); end
    checks++; if (direcao !== 1'b0) begin errors++; $display("FAIL down_final_dir got %b exp 0", direcao); end
  endtask

  task automatic test_leading_zero();
    for (int i = 0; i < 14; i++) begin
      tick(4'd7);
      checks++; if (seg !== exp_seg(k) || an !== exp_an(k)) begin errors++; $display("FAIL lead_zero k=%0d got %b/%b exp %b/%b", k, seg, an, exp_seg(k), exp_an(k)); end
    end
  endtask

  task automatic test_random();
    logic [3:0] v;
    v = 4'd0;
    for (int i = 0; i < 160; i++) begin
      if ($urandom_range(0, 2) != 0) v = 4'($urandom_range(0, 15));
      tick(v);
      checks++; if (seg !== exp_seg(k) || an !== exp_an(k)) begin errors++; $display("FAIL rand_disp k=%0d got %b/%b exp %b/%b", k, seg, an, exp_seg(k), exp_an(k)); end
      checks++; if (mudou !== exp_mudou(k) || direcao !== exp_dir(k)) begin errors++; $display("FAIL rand_flags k=%0d got %b/%b exp %b/%b", k, mudou, direcao, exp_mudou(k), exp_dir(k)); end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) tick(4'($urandom_range(10, 15)));
    #3;
    resert = 1'b1;
    #1;
    checks++; if (seg !== 7'h7F || an !== 2'b11) begin errors++; $display("FAIL mid_reset_disp got %b/%b exp 1111111/11", seg, an); end
    checks++; if (mudou !== 1'b0 || direcao !== 1'b1) begin errors++; $display("FAIL mid_reset_flags got %b/%b exp 0/1", mudou, direcao); end
    @(posedge clock);
    #3;
    resert = 1'b0;
    k = 0;
    for (int i = 0; i < 12; i++) begin
      tick(4'd3);
      checks++; if (seg !== exp_seg(k) || an !== exp_an(k)) begin errors++; $display("FAIL mid_restart k=%0d got %b/%b exp %b/%b", k, seg, an, exp_seg(k), exp_an(k)); end
    end
  endtask

  initial begin
    for (int i = 0; i <= HMAX; i++) hist[i] = 0;
    test_reset();
    test_scan();
    test_up();
    test_two_digit();
    test_down_hold();
    test_leading_zero();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
